// File: rtl/clock_enable_pkg.sv
// Shared types and counter-width helpers for the clock-enable sequencer.
// The sequencer FSM and the per-channel dividers both import this package.
package clock_enable_pkg;

  localparam int unsigned MAX_CH = 8;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_HOLD    = 2'd1,
    S_STAGGER = 2'd2,
    S_RUN     = 2'd3
  } seq_state_t;

  // Width of a counter that must reach rst_cycles without wrapping.
  function automatic int unsigned hold_cnt_w(input int unsigned rst_cycles);
    int unsigned w;
    w = $clog2(rst_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the counter spanning the last channel's release offset; never below 1 bit.
  function automatic int unsigned stagger_cnt_w(input int unsigned num_ch,
                                                input int unsigned stagger);
    int unsigned w;
    w = $clog2((num_ch - 1) * stagger + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One derived-clock channel: divisor latch, phase counter, registered ce and clk_div.
// The divisor is latched at release and at every terminal count; a zero divisor parks the channel.
module clock_div_channel
  import clock_enable_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             ce,
  output logic             clk_div
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] act_next;
  logic             ce_next;
  logic             clk_div_next;

  // A new period starts on release (act_div is 0 in reset), after a terminal count,
  // or every cycle while parked on a zero divisor.
  always_comb begin
    cnt_next     = '0;
    act_next     = '0;
    ce_next      = 1'b0;
    clk_div_next = 1'b0;
    if (run) begin
      if ((act_div == '0) || (cnt == act_div - DIV_W'(1))) begin
        act_next = div;
        cnt_next = '0;
      end else begin
        act_next = act_div;
        cnt_next = cnt + DIV_W'(1);
      end
      ce_next      = (act_next != '0) && (cnt_next == act_next - DIV_W'(1));
      clk_div_next = (cnt_next < (act_next >> 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      act_div <= '0;
      ce      <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      act_div <= act_next;
      ce      <= ce_next;
      clk_div <= clk_div_next;
    end
  end

endmodule

// File: rtl/clock_enable_sequencer.sv
// Lock-qualified reset sequencer releasing NUM_CH divider channels in a staggered order.
// Any sampled loss of lock drops every channel back into reset and restarts the sequence.
module clock_enable_sequencer
  import clock_enable_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RST_CYCLES = 32,
  parameter int unsigned STAGGER    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    locked,
  input  logic [NUM_CH*DIV_W-1:0] div,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH-1:0]       reset_ch,
  output logic                    all_released
);

  localparam int unsigned HOLD_W   = hold_cnt_w(RST_CYCLES);
  localparam int unsigned STG_W    = stagger_cnt_w(NUM_CH, STAGGER);
  localparam int unsigned STG_LAST = (NUM_CH - 1) * STAGGER;

  seq_state_t          state;
  seq_state_t          state_next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_next;
  logic [STG_W-1:0]    stg_cnt;
  logic [STG_W-1:0]    stg_next;
  logic [NUM_CH-1:0]   reset_ch_next;
  logic                all_released_next;
  logic [NUM_CH-1:0]   run_c;

  // Next-state and next-reset decode; loss of lock overrides every state.
  always_comb begin
    state_next    = state;
    hold_next     = hold_cnt;
    stg_next      = stg_cnt;
    reset_ch_next = reset_ch;
    unique case (state)
      S_WAIT: begin
        reset_ch_next = '1;
        hold_next     = '0;
        stg_next      = '0;
        if (locked) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_W'(RST_CYCLES)) begin
          state_next = (STG_LAST == 0) ? S_RUN : S_STAGGER;
          stg_next   = '0;
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (k * STAGGER == 0) begin
              reset_ch_next[k] = 1'b0;
            end
          end
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      S_STAGGER: begin
        stg_next = stg_cnt + STG_W'(1);
        for (int unsigned k = 1; k < NUM_CH; k++) begin
          if (stg_next == STG_W'(k * STAGGER)) begin
            reset_ch_next[k] = 1'b0;
          end
        end
        if (stg_next == STG_W'(STG_LAST)) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        reset_ch_next = '0;
      end
      default: begin
        state_next    = S_WAIT;
        reset_ch_next = '1;
      end
    endcase
    if (!locked) begin
      state_next    = S_WAIT;
      hold_next     = '0;
      stg_next      = '0;
      reset_ch_next = '1;
    end
  end

  assign all_released_next = ~|reset_ch_next;
  // Channels follow the reset they are about to receive, so they start and stop on the same edge.
  assign run_c = ~reset_ch_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_WAIT;
      hold_cnt     <= '0;
      stg_cnt      <= '0;
      reset_ch     <= '1;
      all_released <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      stg_cnt      <= stg_next;
      reset_ch     <= reset_ch_next;
      all_released <= all_released_next;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clock_div_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run_c[k]),
      .div     (div[k*DIV_W +: DIV_W]),
      .ce      (ce[k]),
      .clk_div (clk_div[k])
    );
  end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Bench for clock_enable_sequencer: directed phases plus a randomized phase, all checked
// against a model built from release times and queued per-period output patterns.
module tb_clock_enable_sequencer;

  localparam int unsigned NCH  = 3;
  localparam int unsigned DW   = 8;
  localparam int unsigned RSTC = 6;
  localparam int unsigned STG  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              locked;
  logic [NCH*DW-1:0] div;
  logic [NCH-1:0]    ce;
  logic [NCH-1:0]    clk_div;
  logic [NCH-1:0]    reset_ch;
  logic              all_released;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: consecutive lock-qualified edges, and per channel the remaining
  // {ce, clk_div} pattern of the current period.
  int             age = 0;
  logic [1:0]     pq[NCH][$];
  logic [NCH-1:0] exp_rc;
  logic [NCH-1:0] exp_ce;
  logic [NCH-1:0] exp_cd;
  logic           exp_all;

  clock_enable_sequencer #(
    .NUM_CH     (NCH),
    .DIV_W      (DW),
    .RST_CYCLES (RSTC),
    .STAGGER    (STG)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .locked       (locked),
    .div          (div),
    .ce           (ce),
    .clk_div      (clk_div),
    .reset_ch     (reset_ch),
    .all_released (all_released)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int k, input int v);
    div[k*DW +: DW] = DW'(v);
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled there.
  task automatic model_edge();
    int d;
    bit rel;
    if (!reset_n || !locked) age = 0;
    else age++;
    for (int k = 0; k < NCH; k++) begin
      rel = reset_n && (age >= int'(RSTC) + 2 + k * int'(STG));
      exp_rc[k] = !rel;
      exp_ce[k] = 1'b0;
      exp_cd[k] = 1'b0;
      if (!rel) begin
        pq[k].delete();
      end else begin
        if (pq[k].size() == 0) begin
          d = int'(div[k*DW +: DW]);
          for (int i = 0; i < d; i++) pq[k].push_back({i == d - 1, i < d / 2});
        end
        if (pq[k].size() != 0) begin
          {exp_ce[k], exp_cd[k]} = pq[k].pop_front();
        end
      end
    end
    exp_all = (exp_rc == '0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("reset_ch", 32'(reset_ch), 32'(exp_rc));
    chk("ce", 32'(ce), 32'(exp_ce));
    chk("clk_div", 32'(clk_div), 32'(exp_cd));
    chk("all_released", 32'(all_released), 32'(exp_all));
  endtask

  // Step through a full release sequence and check each channel's release edge.
  task automatic measure_release(input string tag);
    int f0, f1, f2, fa;
    f0 = -1; f1 = -1; f2 = -1; fa = -1;
    for (int n = 1; n <= int'(RSTC) + 2 + 2 * int'(STG) + 4; n++) begin
      step();
      if (f0 < 0 && reset_ch[0] == 1'b0) f0 = n;
      if (f1 < 0 && reset_ch[1] == 1'b0) f1 = n;
      if (f2 < 0 && reset_ch[2] == 1'b0) f2 = n;
      if (fa < 0 && all_released == 1'b1) fa = n;
    end
    chk({tag, "_ch0"}, 32'(f0), 32'(RSTC + 2));
    chk({tag, "_ch1"}, 32'(f1), 32'(RSTC + 2 + STG));
    chk({tag, "_ch2"}, 32'(f2), 32'(RSTC + 2 + 2 * STG));
    chk({tag, "_all"}, 32'(fa), 32'(RSTC + 2 + 2 * STG));
  endtask

  initial begin
    int p1, p2, hi, t, c1, c2, n;
    logic prev;

    reset_n = 1'b0;
    locked  = 1'b1;
    div     = '0;
    set_div(0, 2);
    set_div(1, 5);
    set_div(2, 4);

    // Held in reset with lock present.
    repeat (3) step();
    chk("rst_reset_ch", 32'(reset_ch), 32'h7);
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_clk_div", 32'(clk_div), 32'h0);
    chk("rst_all", 32'(all_released), 32'h0);

    reset_n = 1'b1;
    measure_release("boot");

    // Divide-by-5 shape on channel 1.
    p1 = -1; p2 = -1; hi = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ce[1]) begin
        if (p1 < 0) p1 = i;
        else if (p2 < 0) p2 = i;
      end
      if (p1 >= 0 && p2 < 0 && i > p1 && clk_div[1]) hi++;
    end
    chk("ch1_period", 32'(p2 - p1), 32'd5);
    chk("ch1_high", 32'(hi), 32'd2);

    // Divide-by-2 toggles every cycle.
    prev = clk_div[0];
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ch0_toggle", 32'(clk_div[0]), 32'(!prev));
      prev = clk_div[0];
    end

    // Channel 2: 4 -> 3 two cycles into a period.
    t = -1;
    for (int i = 0; i < 10 && t < 0; i++) begin
      step();
      if (ce[2]) t = i;
    end
    chk("ch2_found", 32'(t >= 0), 32'd1);
    step();
    step();
    set_div(2, 3);
    c1 = -1; c2 = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (ce[2]) begin
        if (c1 < 0) c1 = i;
        else if (c2 < 0) c2 = i;
      end
    end
    chk("ch2_old_period", 32'(c1), 32'd2);
    chk("ch2_new_period", 32'(c2 - c1), 32'd3);

    // Randomized divisors, lock drops and resets.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 7) == 0) set_div(k, int'($urandom_range(0, 6)));
      end
      locked  = ($urandom_range(0, 59) != 0);
      reset_n = ($urandom_range(0, 149) != 0);
      step();
    end

    reset_n = 1'b1;
    locked  = 1'b1;
    set_div(0, 2);
    set_div(1, 5);
    set_div(2, 3);
    n = 0;
    while (!all_released && n < 40) begin
      step();
      n++;
    end
    chk("resync_done", 32'(all_released), 32'd1);
    repeat (4) step();

    // Single-cycle lock loss in S_RUN.
    locked = 1'b0;
    step();
    locked = 1'b1;
    chk("drop_reset_ch", 32'(reset_ch), 32'h7);
    chk("drop_ce", 32'(ce), 32'h0);
    chk("drop_clk_div", 32'(clk_div), 32'h0);
    chk("drop_all", 32'(all_released), 32'h0);
    measure_release("relock");

    // Zero divisor parks channel 0; divisor 1 pulses every cycle.
    set_div(0, 0);
    repeat (6) step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("div0_ce", 32'(ce[0]), 32'd0);
      chk("div0_clk_div", 32'(clk_div[0]), 32'd0);
    end
    set_div(0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div1_ce", 32'(ce[0]), 32'd1);
      chk("div1_clk_div", 32'(clk_div[0]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_enable_sequencer.md
CLOCK_ENABLE_SEQUENCER -- requirements
Module: clock_enable_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, the number of derived channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, the width of each channel divisor.
REQ-003 SHALL have parameter RST_CYCLES, default 32, the number of lock-qualified cycles before the first release (>=1).
REQ-004 SHALL have parameter STAGGER, default 4, the number of cycles between successive channel releases (0 = simultaneous).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: the reset, synchronous and active-low.
REQ-007 SHALL have port locked, input, 1 bit: PLL lock, already synchronous to clk.
REQ-008 SHALL have port div, input, NUM_CH*DIV_W bits: per-channel divisor, channel k at bits [k*DIV_W +: DIV_W].
REQ-009 SHALL have port ce, output, NUM_CH bits: per-channel one-cycle clock-enable pulse.
REQ-010 SHALL have port clk_div, output, NUM_CH bits: per-channel divided level (data, not a clock net).
REQ-011 SHALL have port reset_ch, output, NUM_CH bits: per-channel reset, active-high.
REQ-012 SHALL have port all_released, output, 1 bit: high when every reset_ch is deasserted.

Function
REQ-013 Sequencer FSM SHALL have states S_WAIT, S_HOLD, S_STAGGER and S_RUN.
REQ-014 S_WAIT: all reset_ch SHALL be 1; on locked=1, go to S_HOLD with hold counter cleared.
REQ-015 S_HOLD: SHALL count cycles with locked=1; after RST_CYCLES, go to S_STAGGER and deassert reset_ch[0].
REQ-016 S_STAGGER: SHALL deassert reset_ch[k] exactly k*STAGGER cycles after reset_ch[0]; once reset_ch[NUM_CH-1] deasserts, go to S_RUN.
REQ-017 all_released SHALL be registered and rise in the same cycle as the last reset_ch deasserts.
REQ-018 locked sampled 0 in any state SHALL cause, on the next cycle: S_WAIT, all reset_ch=1, all_released=0, all ce/clk_div=0, all counters cleared; a single-cycle drop SHALL trigger a full re-sequence.
REQ-019 A divider channel SHALL run only while its reset_ch=0; otherwise cnt=0, ce=0, clk_div=0.
REQ-020 Active divisor d: cnt SHALL count 0..d-1 and wrap.
REQ-021 ce[k] SHALL be high for the single cycle where cnt==d-1; the first pulse is the d-th cycle after reset_ch[k] falls.
REQ-022 clk_div[k] SHALL be 1 while cnt < d/2 (integer division), else 0.
  - d=2 gives toggle every cycle.
  - d=5 gives 2 high, 3 low.
  - d=1 gives ce always high and clk_div always 0.
REQ-023 The active divisor SHALL be loaded from div at channel release and at each terminal count; div changes mid-period SHALL NOT affect the current period.
REQ-024 Active divisor 0 SHALL disable the channel (cnt, ce and clk_div held at 0) and SHALL re-sample div every cycle.
REQ-025 The hold counter SHALL be $clog2(RST_CYCLES+1) bits; the stagger counter $clog2((NUM_CH-1)*STAGGER+1) bits, minimum 1; no counter SHALL overflow.
REQ-026 All outputs SHALL be driven directly from flops.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force S_WAIT, counters 0, active divisors 0, reset_ch all 1, ce 0, clk_div 0, all_released 0, regardless of locked.
REQ-028 reset_n asserted mid-sequence or in S_RUN SHALL take effect on that edge; the sequence restarts from S_WAIT after release.

Structure
REQ-029 Package clock_enable_pkg SHALL hold the FSM state enum and the counter-width helper constants.
REQ-030 Sub-module clock_div_channel (counter, divisor latch, ce/clk_div generation) SHALL be instantiated NUM_CH times in a generate loop; the sequencer FSM SHALL stay in the top module.

Verification
REQ-031 reset_n=0 for 3 cycles, then 1, with locked=1 -> reset_ch[0] falls RST_CYCLES+1 cycles after the first reset_n=1 edge; outputs at reset values before that.
REQ-032 NUM_CH=3, STAGGER=4 -> reset_ch[1] falls 4 cycles and reset_ch[2] 8 cycles after reset_ch[0]; all_released rises with reset_ch[2].
REQ-033 div=2 -> ce every 2nd cycle, clk_div toggles every cycle; div=5 -> ce every 5 cycles, clk_div 2 high / 3 low.
REQ-034 div changed 4->3 two cycles into a period -> that period stays 4 cycles, the following periods are 3.
REQ-035 locked low for 1 cycle in S_RUN -> next cycle all reset_ch=1, ce=0, clk_div=0, all_released=0; full re-sequence follows.
REQ-036 div=0 -> ce and clk_div stay 0 indefinitely; div set to 1 -> ce high every cycle from the next cycle.
